ultrasonic_trigger_ctrl: RTL and testbench

Measurement sequencer for the ultrasonic ranging path. It periodically fires the sensor trigger pulse and issues a one-cycle trig_start to the echo-timing stage. It then waits for that stage's echo_done/echo_value result, or times out. Each result is folded into a 4-sample moving average, and a filtered distance is published to the car controller with a one-cycle valid strobe.

---
 rtl/ultrasonic_trigger_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ultrasonic_trigger_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_trigger_ctrl.sv
// Ultrasonic ranging sequencer: periodic trigger, echo wait with timeout,
// 4-sample moving average and a registered result strobe.
module ultrasonic_trigger_ctrl #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int PERIOD_CYCLES  = 6000000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       trig,
  output logic       trig_start,
  input  logic       echo_done,
  input  logic [9:0] echo_value,
  output logic       busy,
  output logic [9:0] dist_raw,
  output logic [9:0] dist_value,
  output logic       dist_valid,
  output logic       timeout
);

  localparam int TW = (TRIG_CYCLES    > 1024)    ? $clog2(TRIG_CYCLES)    : 10;
  localparam int PW = (PERIOD_CYCLES  > 8388608) ? $clog2(PERIOD_CYCLES)  : 23;
  localparam int WW = (TIMEOUT_CYCLES > 8388608) ? $clog2(TIMEOUT_CYCLES) : 23;

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [WW-1:0] TO_LAST   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_TRIG  = 3'd2,
    S_WAIT  = 3'd3,
    S_AVG   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [9:0]    hist_q [4];
  logic [9:0]    hist_d [4];
  logic [1:0]    wptr_q, wptr_d;
  logic [11:0]   sum_q, sum_d;
  logic [9:0]    sample_q, sample_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic          first_q, first_d;
  logic          trig_q, trig_d;
  logic          trig_start_q, trig_start_d;
  logic          busy_q, busy_d;
  logic [9:0]    dist_raw_q, dist_raw_d;
  logic [9:0]    dist_value_q, dist_value_d;
  logic          dist_valid_q, dist_valid_d;
  logic          timeout_q, timeout_d;
  logic          wr_s;
  logic [9:0]    wr_val_s;

  // Next-state, counters, sample ring update and registered output values.
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    wptr_d       = wptr_q;
    sum_d        = sum_q;
    sample_d     = sample_q;
    tmo_flag_d   = tmo_flag_q;
    first_d      = first_q;
    dist_raw_d   = dist_raw_q;
    dist_value_d = dist_value_q;
    dist_valid_d = 1'b0;
    timeout_d    = 1'b0;
    wr_s         = 1'b0;
    wr_val_s     = 10'd0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_TRIG;
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_TRIG;
        end
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still beats the timeout.
        if (echo_done) begin
          wr_s     = 1'b1;
          wr_val_s = echo_value;
          state_d  = S_AVG;
        end else if (wait_cnt_q == TO_LAST) begin
          wr_s       = 1'b1;
          wr_val_s   = 10'h3FF;
          tmo_flag_d = 1'b1;
          state_d    = S_AVG;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_AVG: begin
        dist_raw_d   = sample_q;
        dist_value_d = sum_q[11:2];
        dist_valid_d = 1'b1;
        timeout_d    = tmo_flag_q;
        tmo_flag_d   = 1'b0;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (period_cnt_q >= PER_LAST) begin
          if (enable) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_s) begin
      sample_d = wr_val_s;
      if (first_q) begin
        for (int i = 0; i < 4; i++) begin
          hist_d[i] = wr_val_s;
        end
        sum_d   = {wr_val_s, 2'b00};
        wptr_d  = 2'd1;
        first_d = 1'b0;
      end else begin
        hist_d[wptr_q] = wr_val_s;
        sum_d          = sum_q - {2'b00, hist_q[wptr_q]} + {2'b00, wr_val_s};
        wptr_d         = wptr_q + 2'd1;
      end
    end else begin
      sample_d = sample_q;
    end

    if (state_q == S_TRIG) begin
      trig_cnt_d = trig_cnt_q + TW'(1);
    end else begin
      trig_cnt_d = '0;
    end

    if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = '0;
    end

    if ((state_d == S_START) || (state_q == S_IDLE)) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + PW'(1);
    end

    trig_d       = (state_d == S_TRIG);
    trig_start_d = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      trig_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      period_cnt_q <= '0;
      hist_q       <= '{default: 10'd0};
      wptr_q       <= 2'd0;
      sum_q        <= 12'd0;
      sample_q     <= 10'd0;
      tmo_flag_q   <= 1'b0;
      first_q      <= 1'b1;
      trig_q       <= 1'b0;
      trig_start_q <= 1'b0;
      busy_q       <= 1'b0;
      dist_raw_q   <= 10'd0;
      dist_value_q <= 10'd0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_cnt_q   <= trig_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      period_cnt_q <= period_cnt_d;
      hist_q       <= hist_d;
      wptr_q       <= wptr_d;
      sum_q        <= sum_d;
      sample_q     <= sample_d;
      tmo_flag_q   <= tmo_flag_d;
      first_q      <= first_d;
      trig_q       <= trig_d;
      trig_start_q <= trig_start_d;
      busy_q       <= busy_d;
      dist_raw_q   <= dist_raw_d;
      dist_value_q <= dist_value_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign trig       = trig_q;
  assign trig_start = trig_start_q;
  assign busy       = busy_q;
  assign dist_raw   = dist_raw_q;
  assign dist_value = dist_value_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ultrasonic_trigger_ctrl.sv
// Directed bench for ultrasonic_trigger_ctrl with TRIG=4, PERIOD=40, TIMEOUT=20.
module tb_ultrasonic_trigger_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       trig;
  logic       trig_start;
  logic       echo_done;
  logic [9:0] echo_value;
  logic       busy;
  logic [9:0] dist_raw;
  logic [9:0] dist_value;
  logic       dist_valid;
  logic       timeout;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int last_start = 0;

  ultrasonic_trigger_ctrl #(
    .TRIG_CYCLES    (4),
    .PERIOD_CYCLES  (40),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .trig       (trig),
    .trig_start (trig_start),
    .echo_done  (echo_done),
    .echo_value (echo_value),
    .busy       (busy),
    .dist_raw   (dist_raw),
    .dist_value (dist_value),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for the next trig_start; optionally checks the 40-cycle period.
  task automatic wait_start(input bit chk_period);
    int n;
    n = 0;
    while (trig_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("trig_start_seen", 32'(trig_start), 32'd1);
    if (chk_period) check("period", 32'(cyc - last_start), 32'd40);
    last_start = cyc;
  endtask

  // From the START cycle: trigger, WAIT exit at WAIT cycle k, result checks.
  task automatic run_meas(input logic [9:0] val, input int k, input bit drive,
                          input bit drop_en, input logic [9:0] exp_raw,
                          input logic [9:0] exp_avg, input logic exp_to);
    step();
    check("trig_rise", 32'(trig), 32'd1);
    check("trig_start_one_cycle", 32'(trig_start), 32'd0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("trig_high", 32'(trig), 32'd1);
    end
    step();
    check("trig_fall", 32'(trig), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    for (int i = 1; i < k; i++) step();
    if (drive) begin
      echo_done  = 1'b1;
      echo_value = val;
    end
    step();
    echo_done  = 1'b0;
    echo_value = 10'd0;
    check("valid_not_early", 32'(dist_valid), 32'd0);
    step();
    check("dist_valid", 32'(dist_valid), 32'd1);
    check("dist_raw", 32'(dist_raw), 32'(exp_raw));
    check("dist_value", 32'(dist_value), 32'(exp_avg));
    check("timeout", 32'(timeout), 32'(exp_to));
    step();
    check("valid_one_cycle", 32'(dist_valid), 32'd0);
    check("timeout_one_cycle", 32'(timeout), 32'd0);
  endtask

  initial begin
    int n_ts;
    rst        = 1'b1;
    enable     = 1'b0;
    echo_done  = 1'b0;
    echo_value = 10'd0;
    step();
    step();
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_trig_start", 32'(trig_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dist_raw", 32'(dist_raw), 32'd0);
    check("rst_dist_value", 32'(dist_value), 32'd0);
    check("rst_dist_valid", 32'(dist_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;

    // Averages 100,125,175,250 then ring wrap evicts first 100 -> 225
    wait_start(1'b0);
    run_meas(10'd100, 5, 1'b1, 1'b0, 10'd100, 10'd100, 1'b0);
    wait_start(1'b1);
    run_meas(10'd200, 3, 1'b1, 1'b0, 10'd200, 10'd125, 1'b0);
    wait_start(1'b1);
    run_meas(10'd300, 1, 1'b1, 1'b0, 10'd300, 10'd175, 1'b0);
    wait_start(1'b1);
    run_meas(10'd400, 7, 1'b1, 1'b0, 10'd400, 10'd250, 1'b0);
    wait_start(1'b1);
    run_meas(10'd0, 5, 1'b1, 1'b0, 10'd0, 10'd225, 1'b0);

    // Timeout: history {0,200,300,400}, evict 200: 900-200+1023=1723 -> 430
    wait_start(1'b1);
    run_meas(10'd0, 20, 1'b0, 1'b0, 10'h3FF, 10'd430, 1'b1);

    // echo_done on the last wait cycle wins: 1723-300+50=1473 -> 368
    wait_start(1'b1);
    run_meas(10'd50, 20, 1'b1, 1'b0, 10'd50, 10'd368, 1'b0);

    // enable dropped in TRIG: 1473-400+10=1083 -> 270, then IDLE at period end
    wait_start(1'b1);
    run_meas(10'd10, 3, 1'b1, 1'b1, 10'd10, 10'd270, 1'b0);
    while (cyc < last_start + 39) step();
    check("busy_before_period_end", 32'(busy), 32'd1);
    step();
    check("idle_after_period_end", 32'(busy), 32'd0);
    n_ts = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (trig_start === 1'b1) n_ts++;
    end
    check("no_trig_start_when_disabled", 32'(n_ts), 32'd0);
    check("idle_busy_stays_low", 32'(busy), 32'd0);

    // Reset during WAIT clears outputs asynchronously
    enable = 1'b1;
    wait_start(1'b0);
    for (int i = 0; i < 6; i++) step();
    check("in_wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("wrst_trig", 32'(trig), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_dist_raw", 32'(dist_raw), 32'd0);
    check("wrst_dist_value", 32'(dist_value), 32'd0);
    check("wrst_dist_valid", 32'(dist_valid), 32'd0);
    check("wrst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Reset during TRIG drops trig immediately
    wait_start(1'b0);
    step();
    check("trig_before_rst", 32'(trig), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("trst_trig", 32'(trig), 32'd0);
    check("trst_busy", 32'(busy), 32'd0);
    check("trst_trig_start", 32'(trig_start), 32'd0);
    rst = 1'b0;

    // First sample after reset is re-preloaded
    wait_start(1'b0);
    run_meas(10'd60, 5, 1'b1, 1'b0, 10'd60, 10'd60, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
